// File: rtl/score_collector.sv
// score_collector: packs one DATA_W score per handshake into a N_CLASSES-wide class-score frame with running argmax.
// Latency: out_valid rises 1 cycle after the accept of the last score (class N_CLASSES-1).
// Backpressure: in_ready drops for the whole hold; the frame is held until out_ready, and no score is taken in that window.
//
// Ports:
//   clk, rst_n     clock (rising edge), synchronous active-low reset
//   flush          drop the partial frame; blocks the accept in that cycle (no effect while holding)
//   in_valid/in_ready/in_data       score input, class order 0..N_CLASSES-1
//   out_valid/out_ready             completed frame handshake
//   out_vec        class k at bits [k*DATA_W +: DATA_W]
//   out_max_idx    argmax of held frame (ties -> highest index)
//   out_max_val    max score of held frame
//   count          scores accepted so far in the current frame
//
// Build option: define SCORE_COLLECTOR_SIGNED_EN to compare scores as two's-complement
// for the running max; otherwise the comparison is unsigned.

module score_collector #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 8,
    parameter int IDX_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_CLASSES*DATA_W-1:0]   out_vec,
    output logic [IDX_W-1:0]              out_max_idx,
    output logic [DATA_W-1:0]             out_max_val,
    output logic [IDX_W-1:0]              count
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    state_t                        state;
    state_t                        state_nxt;

    logic [N_CLASSES*DATA_W-1:0]   vec_q;
    logic [DATA_W-1:0]             run_max_q;
    logic [IDX_W-1:0]              run_idx_q;
    logic [IDX_W-1:0]              cnt_q;
    logic [IDX_W-1:0]              max_idx_q;
    logic [DATA_W-1:0]             max_val_q;

    logic                          accept;
    logic                          last_accept;
    logic                          score_ge;
    logic                          take_new;
    logic [DATA_W-1:0]             new_max;
    logic [IDX_W-1:0]              new_idx;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            COLLECT: begin
                // flush takes priority over a concurrent score
                in_ready = ~flush;
                if (in_valid && !flush && (cnt_q == LAST_IDX)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = COLLECT;
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

    assign accept      = in_valid & in_ready;
    assign last_accept = accept && (cnt_q == LAST_IDX);

    // ------------------------------------------------------------------
    // Running max comparison; >= so that a tie moves the argmax to the
    // later (higher) class index.
    // ------------------------------------------------------------------
`ifdef SCORE_COLLECTOR_SIGNED_EN
    assign score_ge = ($signed(in_data) >= $signed(run_max_q));
`else
    assign score_ge = (in_data >= run_max_q);
`endif

    // First score of a frame seeds the running max regardless of value,
    // so the reset value of the running max never wins a comparison.
    assign take_new = (cnt_q == '0) || score_ge;
    assign new_max  = take_new ? in_data : run_max_q;
    assign new_idx  = take_new ? cnt_q   : run_idx_q;

    // ------------------------------------------------------------------
    // Datapath: slot packing, running max, frame result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q     <= '0;
            run_max_q <= '0;
            run_idx_q <= '0;
            cnt_q     <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
        end else if ((state == COLLECT) && flush) begin
            // Slots keep stale data; they are overwritten as the next frame fills.
            cnt_q     <= '0;
            run_max_q <= '0;
            run_idx_q <= '0;
        end else if (accept) begin
            for (int k = 0; k < N_CLASSES; k++) begin
                if (cnt_q == IDX_W'(k)) begin
                    vec_q[k*DATA_W +: DATA_W] <= in_data;
                end
            end
            if (last_accept) begin
                cnt_q     <= '0;
                max_val_q <= new_max;
                max_idx_q <= new_idx;
                run_max_q <= '0;
                run_idx_q <= '0;
            end else begin
                cnt_q     <= cnt_q + 1'b1;
                run_max_q <= new_max;
                run_idx_q <= new_idx;
            end
        end
    end

    // No accepts occur while holding, so the registered slots and result
    // are stable for the whole out_valid window without a separate copy.
    assign out_vec     = vec_q;
    assign out_max_idx = max_idx_q;
    assign out_max_val = max_val_q;
    assign count       = cnt_q;

endmodule

// File: tb/tb_score_collector.sv
// tb_score_collector: randomized scoreboard bench for score_collector.
// Latency: n/a (bench).
// Backpressure: consumer holds out_ready low for a per-frame number of cycles.

module tb_score_collector;

    localparam int N  = 10;
    localparam int DW = 8;
    localparam int IW = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N*DW-1:0]   out_vec;
    logic [IW-1:0]     out_max_idx;
    logic [DW-1:0]     out_max_val;
    logic [IW-1:0]     count;

    score_collector #(.N_CLASSES(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_vec     (out_vec),
        .out_max_idx (out_max_idx),
        .out_max_val (out_max_val),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N*DW-1:0] vec;
        logic [IW-1:0]   idx;
        logic [DW-1:0]   val;
        int              hold;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  cur[N];
    int          total;
    int          bad;
    longint      t_last;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the frame maximum under the selected ordering, then
    // the highest class index carrying that value.
    function automatic logic greater(input logic [7:0] a, input logic [7:0] b);
`ifdef SCORE_COLLECTOR_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    function automatic exp_t model(input int hold);
        exp_t e;
        logic [7:0] best;
        best = cur[0];
        for (int k = 1; k < N; k++)
            if (greater(cur[k], best)) best = cur[k];
        e.idx = '0;
        for (int k = 0; k < N; k++)
            if (cur[k] == best) e.idx = IW'(k);
        e.val = best;
        e.vec = '0;
        for (int k = 0; k < N; k++) e.vec[k*DW +: DW] = cur[k];
        e.hold = hold;
        return e;
    endfunction

    // Offers cur[0..n-1] in order with random gaps; checks count every cycle.
    task automatic send(input int n, input int gap_pct);
        int k;
        int guard;
        k = 0;
        guard = 0;
        @(posedge clk);
        while (k < n) begin
            #1;
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = cur[k];
            end
            @(negedge clk);
            chk("count_track", 128'(count), 128'(k));
            if (in_valid && in_ready) begin
                @(posedge clk);
                k++;
                guard = 0;
                if (k == N) t_last = $time;
            end else begin
                @(posedge clk);
                guard++;
                if (guard > 500) begin
                    total++;
                    bad++;
                    $display("FAIL in_ready_timeout: got stall want accept within 500 cycles");
                    k = n;
                end
            end
        end
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("count_after", 128'(count), 128'((n == N) ? 0 : n));
    endtask

    task automatic frame(input int gap_pct, input int hold);
        exp_q.push_back(model(hold));
        send(N, gap_pct);
    endtask

    // Monitor / consumer: pops an expectation at each frame presentation.
    initial begin : monitor
        exp_t        e;
        logic        was_v;
        logic        released;
        int          hold_cnt;
        logic [N*DW-1:0] cap_vec;
        logic [IW-1:0]   cap_idx;
        logic [DW-1:0]   cap_val;
        was_v = 1'b0;
        released = 1'b0;
        hold_cnt = 0;
        out_ready = 1'b0;
        e.hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                was_v = 1'b0;
                released = 1'b0;
                out_ready = 1'b0;
                continue;
            end
            if (released) begin
                chk("release_out_valid", 128'(out_valid), 128'(0));
                chk("release_count", 128'(count), 128'(0));
                chk("release_in_ready", 128'(in_ready), 128'(!flush));
                released = 1'b0;
            end
            if (out_valid) begin
                if (!was_v) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: got out_valid want none queued");
                        e.hold = 0;
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_vec", 128'(out_vec), 128'(e.vec));
                        chk("out_max_idx", 128'(out_max_idx), 128'(e.idx));
                        chk("out_max_val", 128'(out_max_val), 128'(e.val));
                        chk("latency", 128'($time), 128'(t_last + 5));
                    end
                    chk("hold_in_ready", 128'(in_ready), 128'(0));
                    cap_vec = out_vec;
                    cap_idx = out_max_idx;
                    cap_val = out_max_val;
                    hold_cnt = 0;
                end else begin
                    chk("stable_vec", 128'(out_vec), 128'(cap_vec));
                    chk("stable_idx", 128'(out_max_idx), 128'(cap_idx));
                    chk("stable_val", 128'(out_max_val), 128'(cap_val));
                    chk("hold_in_ready", 128'(in_ready), 128'(0));
                end
                if (hold_cnt >= e.hold) begin
                    out_ready = 1'b1;
                    released = 1'b1;
                end else begin
                    out_ready = 1'b0;
                    hold_cnt++;
                end
            end else begin
                // out_ready with nothing held must be ignored
                out_ready = 1'($urandom_range(1));
            end
            was_v = out_valid;
        end
    end

    initial begin : main
        int guard;
        total = 0;
        bad = 0;
        t_last = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_out_vec", 128'(out_vec), 128'(0));
        chk("rst_max_idx", 128'(out_max_idx), 128'(0));
        chk("rst_max_val", 128'(out_max_val), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        // Directed frame, immediate consume
        cur = '{8'd5, 8'd9, 8'd3, 8'd200, 8'd17, 8'd200, 8'd1, 8'd0, 8'd4, 8'd8};
        frame(0, 0);
        // Same frame held 20 cycles; the next frame is offered during the hold
        frame(0, 20);
        for (int k = 0; k < N; k++) cur[k] = 8'($urandom);
        frame(30, 2);

        // Partial frame then flush with a concurrent score
        for (int k = 0; k < N; k++) cur[k] = 8'($urandom);
        send(4, 0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = cur[4];
        @(negedge clk);
        chk("flush_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_count", 128'(count), 128'(0));
        for (int k = 0; k < N; k++) cur[k] = 8'd7;
        frame(0, 1);

        // Max 250 at index 0 with gapped valid
        cur[0] = 8'd250;
        for (int k = 1; k < N; k++) cur[k] = 8'($urandom_range(249));
        frame(50, 0);

        // Signedness-dependent frame
        cur = '{8'h80, 8'hFF, 8'h05, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90};
        frame(0, 0);

        // Random frames, some with forced ties
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < N; k++) cur[k] = 8'($urandom);
            if (f % 2 == 1) cur[$urandom_range(N-1)] = cur[$urandom_range(N-1)];
            frame($urandom_range(40), $urandom_range(5));
        end

        // Reset while holding a frame
        for (int k = 0; k < N; k++) cur[k] = 8'($urandom_range(255, 1));
        frame(0, 1000);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("hold_reached", 128'(out_valid), 128'(1));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("hrst_out_valid", 128'(out_valid), 128'(0));
        chk("hrst_out_vec", 128'(out_vec), 128'(0));
        chk("hrst_max_idx", 128'(out_max_idx), 128'(0));
        chk("hrst_max_val", 128'(out_max_val), 128'(0));
        chk("hrst_count", 128'(count), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Recovery frame
        for (int k = 0; k < N; k++) cur[k] = 8'($urandom);
        frame(20, 3);

        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d frames pending want 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
